// File: rtl/pe_array_sequencer.sv
// pe_array_sequencer: control FSM for the three-PE systolic datapath.
// A run broadcasts FILT_WORDS filter words into every PE, then for each ifmap
// pass loads IF_WORDS words into PE0, PE1 and PE2 in turn, pulses start_PE,
// waits for all three PEs to finish and for the result chain to drain.
// The filter stays resident across passes.
//
// Ports:
//   i_clk, i_rst           clock (rising edge), async active-low reset
//   i_start                1-cycle run request, ignored while busy
//   i_cfg_*                PE config and pass count, latched at accepted start
//   i_filt_full, i_if_full PE buffer full flags (stall the matching load)
//   i_pe_done              per-PE completion flags
//   i_res_empty_last       last-PE result buffer empty
//   o_sel_addr_SRAM        1 = FILTER counter drives SRAM address, 0 = IFG counter
//   o_filt_cnt_en, o_ifg_cnt_en   address counter advance
//   o_filter_wen, o_ifmap_wen     PE buffer writes (ifmap one-hot)
//   o_start_PE             1-cycle PE start pulse
//   o_mode, o_filt_len, o_stride_len  latched config
//   o_busy, o_done         run status
module pe_array_sequencer #(
    parameter int unsigned FILT_WORDS     = 4,
    parameter int unsigned IF_WORDS       = 8,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned DRAIN_IDLE_CYC = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_cfg_mode,
    input  logic             i_cfg_filt_len,
    input  logic             i_cfg_stride_len,
    input  logic [CNT_W-1:0] i_cfg_num_passes,
    input  logic             i_filt_full,
    input  logic [2:0]       i_if_full,
    input  logic [2:0]       i_pe_done,
    input  logic             i_res_empty_last,
    output logic             o_sel_addr_SRAM,
    output logic             o_filt_cnt_en,
    output logic             o_ifg_cnt_en,
    output logic             o_filter_wen,
    output logic [2:0]       o_ifmap_wen,
    output logic             o_start_PE,
    output logic             o_mode,
    output logic             o_filt_len,
    output logic             o_stride_len,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned IDLE_W = (DRAIN_IDLE_CYC > 1) ? $clog2(DRAIN_IDLE_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_FILT,
        S_LOAD_IF,
        S_START,
        S_COMPUTE,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_word_cnt;
    logic [CNT_W-1:0]   r_pass_cnt;
    logic [CNT_W-1:0]   r_num_passes;
    logic [1:0]         r_pe_idx;
    logic [IDLE_W-1:0]  r_idle_cnt;
    logic               r_mode;
    logic               r_filt_len;
    logic               r_stride_len;

    logic               w_if_full_cur;
    logic [2:0]         w_pe_onehot;
    logic               w_filt_wr;
    logic               w_filt_last;
    logic               w_if_wr;
    logic               w_if_word_last;
    logic               w_if_last;
    logic               w_drain_hit;
    logic               w_last_pass;

    // Full flag and write-enable bit of the PE currently being loaded
    always_comb begin
        w_if_full_cur = 1'b1;
        w_pe_onehot   = 3'b000;
        case (r_pe_idx)
            2'd0: begin w_if_full_cur = i_if_full[0]; w_pe_onehot = 3'b001; end
            2'd1: begin w_if_full_cur = i_if_full[1]; w_pe_onehot = 3'b010; end
            2'd2: begin w_if_full_cur = i_if_full[2]; w_pe_onehot = 3'b100; end
            default: begin w_if_full_cur = 1'b1; w_pe_onehot = 3'b000; end
        endcase
    end

    assign w_filt_wr      = (r_state == S_LOAD_FILT) && !i_filt_full;
    assign w_filt_last    = w_filt_wr && (r_word_cnt == CNT_W'(FILT_WORDS - 1));
    assign w_if_wr        = (r_state == S_LOAD_IF) && !w_if_full_cur;
    assign w_if_word_last = w_if_wr && (r_word_cnt == CNT_W'(IF_WORDS - 1));
    assign w_if_last      = w_if_word_last && (r_pe_idx == 2'd2);
    assign w_drain_hit    = (r_state == S_DRAIN) && i_res_empty_last &&
                            (r_idle_cnt == IDLE_W'(DRAIN_IDLE_CYC - 1));
    assign w_last_pass    = (r_pass_cnt == (r_num_passes - CNT_W'(1)));

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (i_start) w_next = S_LOAD_FILT;
            S_LOAD_FILT: if (w_filt_last) w_next = S_LOAD_IF;
            S_LOAD_IF:   if (w_if_last) w_next = S_START;
            S_START:     w_next = S_COMPUTE;
            S_COMPUTE:   if (i_pe_done == 3'b111) w_next = S_DRAIN;
            S_DRAIN:     if (w_drain_hit) w_next = w_last_pass ? S_FINISH : S_LOAD_IF;
            S_FINISH:    w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Output decode; enables follow the full flags in the same cycle
    always_comb begin
        o_sel_addr_SRAM = 1'b0;
        o_filt_cnt_en   = 1'b0;
        o_ifg_cnt_en    = 1'b0;
        o_filter_wen    = 1'b0;
        o_ifmap_wen     = 3'b000;
        o_start_PE      = 1'b0;
        o_busy          = 1'b0;
        o_done          = 1'b0;
        case (r_state)
            S_LOAD_FILT: begin
                o_sel_addr_SRAM = 1'b1;
                o_filter_wen    = w_filt_wr;
                o_filt_cnt_en   = w_filt_wr;
                o_busy          = 1'b1;
            end
            S_LOAD_IF: begin
                o_ifmap_wen  = w_if_wr ? w_pe_onehot : 3'b000;
                o_ifg_cnt_en = w_if_wr;
                o_busy       = 1'b1;
            end
            S_START: begin
                o_start_PE = 1'b1;
                o_busy     = 1'b1;
            end
            S_COMPUTE, S_DRAIN: o_busy = 1'b1;
            S_FINISH:           o_done = 1'b1;
            default: ;
        endcase
    end

    assign o_mode       = r_mode;
    assign o_filt_len   = r_filt_len;
    assign o_stride_len = r_stride_len;

    // Word / PE / pass / drain-idle counters and config latch
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_word_cnt   <= '0;
            r_pass_cnt   <= '0;
            r_num_passes <= '0;
            r_pe_idx     <= '0;
            r_idle_cnt   <= '0;
            r_mode       <= 1'b0;
            r_filt_len   <= 1'b0;
            r_stride_len <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mode       <= i_cfg_mode;
                        r_filt_len   <= i_cfg_filt_len;
                        r_stride_len <= i_cfg_stride_len;
                        // A pass count of zero runs one pass
                        r_num_passes <= (i_cfg_num_passes == '0) ? CNT_W'(1) : i_cfg_num_passes;
                        r_pass_cnt   <= '0;
                        r_word_cnt   <= '0;
                        r_pe_idx     <= '0;
                    end
                end
                S_LOAD_FILT: begin
                    if (w_filt_wr) begin
                        if (w_filt_last) begin
                            r_word_cnt <= '0;
                            r_pe_idx   <= '0;
                        end else begin
                            r_word_cnt <= r_word_cnt + CNT_W'(1);
                        end
                    end
                end
                S_LOAD_IF: begin
                    if (w_if_wr) begin
                        if (w_if_word_last) begin
                            r_word_cnt <= '0;
                            r_pe_idx   <= (r_pe_idx == 2'd2) ? 2'd0 : r_pe_idx + 2'd1;
                        end else begin
                            r_word_cnt <= r_word_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // Any non-empty cycle restarts the quiet-period count
                    if (!i_res_empty_last) begin
                        r_idle_cnt <= '0;
                    end else if (w_drain_hit) begin
                        r_idle_cnt <= '0;
                        if (!w_last_pass) begin
                            r_pass_cnt <= r_pass_cnt + CNT_W'(1);
                            r_pe_idx   <= '0;
                            r_word_cnt <= '0;
                        end
                    end else begin
                        r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
                    end
                end
                default: r_idle_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Directed bench for pe_array_sequencer (FILT_WORDS=4, IF_WORDS=8, DRAIN_IDLE_CYC=4).
module tb_pe_array_sequencer;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             cfg_mode;
    logic             cfg_filt_len;
    logic             cfg_stride_len;
    logic [CNT_W-1:0] cfg_num_passes;
    logic             filt_full;
    logic [2:0]       if_full;
    logic [2:0]       pe_done;
    logic             res_empty_last;
    logic             sel_addr;
    logic             filt_cnt_en;
    logic             ifg_cnt_en;
    logic             filter_wen;
    logic [2:0]       ifmap_wen;
    logic             start_pe;
    logic             mode;
    logic             filt_len;
    logic             stride_len;
    logic             busy;
    logic             done;

    int n_pass = 0;
    int n_tot  = 0;

    int m_fw = 0, m_ifw = 0, m_ifg = 0, m_pe1 = 0, m_spe = 0, m_done = 0, m_multi = 0;
    int b_fw, b_ifw, b_ifg, b_pe1, b_spe, b_done;
    int n;

    logic drain_pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    always #5 clk = ~clk;

    pe_array_sequencer #(
        .FILT_WORDS(4), .IF_WORDS(8), .CNT_W(CNT_W), .DRAIN_IDLE_CYC(4)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_start          (start),
        .i_cfg_mode       (cfg_mode),
        .i_cfg_filt_len   (cfg_filt_len),
        .i_cfg_stride_len (cfg_stride_len),
        .i_cfg_num_passes (cfg_num_passes),
        .i_filt_full      (filt_full),
        .i_if_full        (if_full),
        .i_pe_done        (pe_done),
        .i_res_empty_last (res_empty_last),
        .o_sel_addr_SRAM  (sel_addr),
        .o_filt_cnt_en    (filt_cnt_en),
        .o_ifg_cnt_en     (ifg_cnt_en),
        .o_filter_wen     (filter_wen),
        .o_ifmap_wen      (ifmap_wen),
        .o_start_PE       (start_pe),
        .o_mode           (mode),
        .o_filt_len       (filt_len),
        .o_stride_len     (stride_len),
        .o_busy           (busy),
        .o_done           (done)
    );

    wire [9:0]  w_obs = {sel_addr, filt_cnt_en, ifg_cnt_en, filter_wen, ifmap_wen, start_pe, busy, done};
    wire [12:0] w_all = {w_obs, mode, filt_len, stride_len};
    wire [2:0]  w_cfg = {mode, filt_len, stride_len};

    // Expected control vector: counter enables track their write enables
    function automatic logic [9:0] ev(input logic sel, input logic fw, input logic [2:0] ifw,
                                      input logic spe, input logic bsy, input logic dn);
        return {sel, fw, |ifw, fw, ifw, spe, bsy, dn};
    endfunction

    // Per-cycle activity counters, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            m_fw   += int'(filter_wen);
            m_ifw  += int'($countones(ifmap_wen));
            m_ifg  += int'(ifg_cnt_en);
            m_pe1  += int'(ifmap_wen[1]);
            m_spe  += int'(start_pe);
            m_done += int'(done);
            if ($countones(ifmap_wen) > 1) m_multi += 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_fw = m_fw; b_ifw = m_ifw; b_ifg = m_ifg; b_pe1 = m_pe1; b_spe = m_spe; b_done = m_done;
    endtask

    // Run with no backpressure; cyc = cycles from entering LOAD_FILT to FINISH
    task automatic run_count(input logic [CNT_W-1:0] np, output int cyc);
        cfg_num_passes = np;
        pe_done        = 3'b111;
        res_empty_last = 1'b1;
        start          = 1'b1;
        cycle();
        start = 1'b0;
        cyc   = 0;
        while (cyc < 1000) begin
            #1;
            if (done === 1'b1) break;
            cycle();
            cyc++;
        end
        cycle();
        pe_done = 3'b000;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; cfg_mode = 1'b0; cfg_filt_len = 1'b0; cfg_stride_len = 1'b0;
        cfg_num_passes = '0; filt_full = 1'b0; if_full = 3'b000; pe_done = 3'b000;
        res_empty_last = 1'b0;
        #2;
        chk("reset_outputs", 32'(w_all), 32'd0);
        repeat (2) cycle();
        rst = 1'b1;
        res_empty_last = 1'b1;
        cfg_num_passes = 8'd1;
        for (int i = 0; i < 3; i++) begin #1 chk("idle_quiet", 32'(w_all), 32'd0); cycle(); end

        // Basic single-pass run, cycle by cycle
        snap();
        start = 1'b1;
        #1 chk("t2_idle_accept", 32'(w_obs), 32'(ev(0, 0, 3'b000, 0, 0, 0)));
        cycle();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t2_filt", 32'(w_obs), 32'(ev(1, 1, 3'b000, 0, 1, 0))); cycle();
        end
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 8; i++) begin
                #1 chk("t2_ifmap", 32'(w_obs), 32'(ev(0, 0, 3'(1 << p), 0, 1, 0))); cycle();
            end
        end
        #1 chk("t2_start_pe", 32'(w_obs), 32'(ev(0, 0, 3'b000, 1, 1, 0))); cycle();
        #1 chk("t2_compute_wait", 32'(w_obs), 32'(ev(0, 0, 3'b000, 0, 1, 0))); cycle();
        pe_done = 3'b111;
        #1 chk("t2_compute_done", 32'(w_obs), 32'(ev(0, 0, 3'b000, 0, 1, 0))); cycle();
        pe_done = 3'b000;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t2_drain", 32'(w_obs), 32'(ev(0, 0, 3'b000, 0, 1, 0))); cycle();
        end
        #1 chk("t2_done", 32'(w_obs), 32'(ev(0, 0, 3'b000, 0, 0, 1))); cycle();
        #1 chk("t2_idle_after", 32'(w_obs), 32'd0);
        chk("t2_filt_writes", 32'(m_fw - b_fw), 32'd4);
        chk("t2_ifg_adv", 32'(m_ifg - b_ifg), 32'd24);

        // Backpressure, partial done and interrupted drain
        snap();
        start = 1'b1; cycle(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin #1 chk("t3_filt_pre", 32'(w_obs), 32'(ev(1, 1, 3'b000, 0, 1, 0))); cycle(); end
        filt_full = 1'b1;
        for (int i = 0; i < 3; i++) begin #1 chk("t3_filt_stall", 32'(w_obs), 32'(ev(1, 0, 3'b000, 0, 1, 0))); cycle(); end
        filt_full = 1'b0;
        for (int i = 0; i < 2; i++) begin #1 chk("t3_filt_post", 32'(w_obs), 32'(ev(1, 1, 3'b000, 0, 1, 0))); cycle(); end
        if_full = 3'b100;
        for (int i = 0; i < 8; i++) begin #1 chk("t3_pe0", 32'(w_obs), 32'(ev(0, 0, 3'b001, 0, 1, 0))); cycle(); end
        if_full = 3'b000;
        for (int i = 0; i < 3; i++) begin #1 chk("t3_pe1_pre", 32'(w_obs), 32'(ev(0, 0, 3'b010, 0, 1, 0))); cycle(); end
        if_full = 3'b010;
        for (int i = 0; i < 5; i++) begin #1 chk("t3_pe1_stall", 32'(w_obs), 32'(ev(0, 0, 3'b000, 0, 1, 0))); cycle(); end
        if_full = 3'b000;
        for (int i = 0; i < 5; i++) begin #1 chk("t3_pe1_post", 32'(w_obs), 32'(ev(0, 0, 3'b010, 0, 1, 0))); cycle(); end
        for (int i = 0; i < 8; i++) begin #1 chk("t3_pe2", 32'(w_obs), 32'(ev(0, 0, 3'b100, 0, 1, 0))); cycle(); end
        #1 chk("t3_start_pe", 32'(w_obs), 32'(ev(0, 0, 3'b000, 1, 1, 0))); cycle();
        pe_done = 3'b011;
        for (int i = 0; i < 5; i++) begin #1 chk("t4_partial_done", 32'(w_obs), 32'(ev(0, 0, 3'b000, 0, 1, 0))); cycle(); end
        pe_done = 3'b111;
        #1 chk("t4_compute_done", 32'(w_obs), 32'(ev(0, 0, 3'b000, 0, 1, 0))); cycle();
        pe_done = 3'b000;
        for (int i = 0; i < 7; i++) begin
            res_empty_last = drain_pat[i];
            #1 chk("t4_drain", 32'(w_obs), 32'(ev(0, 0, 3'b000, 0, 1, 0))); cycle();
        end
        res_empty_last = 1'b1;
        #1 chk("t4_done", 32'(w_obs), 32'(ev(0, 0, 3'b000, 0, 0, 1))); cycle();
        chk("t3_filt_writes", 32'(m_fw - b_fw), 32'd4);
        chk("t3_pe1_writes", 32'(m_pe1 - b_pe1), 32'd8);
        chk("t3_ifg_adv", 32'(m_ifg - b_ifg), 32'd24);

        // Multi-pass, then zero passes treated as one
        snap();
        run_count(8'd3, n);
        chk("t5_cycles_3", 32'(n), 32'd94);
        chk("t5_filt_writes_3", 32'(m_fw - b_fw), 32'd4);
        chk("t5_ifmap_writes_3", 32'(m_ifw - b_ifw), 32'd72);
        chk("t5_ifg_adv_3", 32'(m_ifg - b_ifg), 32'd72);
        chk("t5_start_pe_3", 32'(m_spe - b_spe), 32'd3);
        chk("t5_done_3", 32'(m_done - b_done), 32'd1);
        snap();
        run_count(8'd0, n);
        chk("t5_cycles_0", 32'(n), 32'd34);
        chk("t5_ifmap_writes_0", 32'(m_ifw - b_ifw), 32'd24);
        chk("t5_start_pe_0", 32'(m_spe - b_spe), 32'd1);
        chk("t5_done_0", 32'(m_done - b_done), 32'd1);

        // Config latch, start while busy and start in FINISH ignored
        snap();
        cfg_mode = 1'b1; cfg_filt_len = 1'b0; cfg_stride_len = 1'b1; cfg_num_passes = 8'd1;
        pe_done = 3'b111; res_empty_last = 1'b1;
        start = 1'b1; cycle(); start = 1'b0;
        cfg_mode = 1'b0; cfg_filt_len = 1'b1; cfg_stride_len = 1'b0; cfg_num_passes = 8'd5;
        #1 chk("t6_cfg_latched", 32'(w_cfg), 32'h5); cycle();
        start = 1'b1;
        #1 chk("t6_busy_start", 32'(w_obs), 32'(ev(1, 1, 3'b000, 0, 1, 0))); cycle();
        start = 1'b0;
        n = 2;
        while (n < 1000) begin
            #1;
            if (done === 1'b1) break;
            cycle();
            n++;
        end
        chk("t6_cycles", 32'(n), 32'd34);
        chk("t6_cfg_hold", 32'(w_cfg), 32'h5);
        start = 1'b1;
        cycle();
        #1 chk("t6_finish_start_ignored", 32'(w_obs), 32'd0);
        chk("t6_start_pe", 32'(m_spe - b_spe), 32'd1);
        chk("t6_done", 32'(m_done - b_done), 32'd1);
        cycle();
        start = 1'b0;
        #1 chk("t6_restart", 32'(w_obs), 32'(ev(1, 1, 3'b000, 0, 1, 0)));
        chk("t6_cfg_new", 32'(w_cfg), 32'h2);

        // Async reset in the middle of loading PE1
        repeat (12) cycle();
        #1 chk("t1_pre_reset", 32'(w_obs), 32'(ev(0, 0, 3'b010, 0, 1, 0)));
        rst = 1'b0;
        #1 chk("t1_async_reset", 32'(w_all), 32'd0);
        cycle();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin #1 chk("t1_idle_quiet", 32'(w_all), 32'd0); cycle(); end
        chk("ifmap_onehot", 32'(m_multi), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
